// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: sequencer states, requester identities
// and the address-width helper used by the interface and the top.
package ram_arb_pkg;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} arb_state_t;

   // Values double as bit positions in the arbiter req/grant vectors.
   typedef enum logic {WRITE = 1'b0, READ = 1'b1} requester_t;

   function automatic int addr_bits(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester handshakes plus the RAM-side port, bundled for the arbiter.
interface ram_port_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int NUM_DATA_BITS = 32,
   parameter int NUM_RAM_WORDS = 19
) ();

   localparam int ADDR_BITS = addr_bits(NUM_RAM_WORDS);

   logic                     wr_valid_in;
   logic                     wr_ready_out;
   logic [ADDR_BITS-1:0]     wr_address_in;
   logic [NUM_DATA_BITS-1:0] wr_data_in;
   logic                     rd_valid_in;
   logic                     rd_ready_out;
   logic [ADDR_BITS-1:0]     rd_address_in;
   logic                     rd_valid_out;
   logic [NUM_DATA_BITS-1:0] rd_data_out;
   logic                     ram_write_enable_out;
   logic [ADDR_BITS-1:0]     ram_address_out;
   logic [NUM_DATA_BITS-1:0] ram_data_out;
   logic [NUM_DATA_BITS-1:0] ram_data_in;
   logic                     init_done_out;
   logic                     addr_error_out;

   modport master (
      output wr_valid_in, wr_address_in, wr_data_in,
      output rd_valid_in, rd_address_in, ram_data_in,
      input  wr_ready_out, rd_ready_out, rd_valid_out, rd_data_out,
      input  ram_write_enable_out, ram_address_out, ram_data_out,
      input  init_done_out, addr_error_out
   );

   modport slave (
      input  wr_valid_in, wr_address_in, wr_data_in,
      input  rd_valid_in, rd_address_in, ram_data_in,
      output wr_ready_out, rd_ready_out, rd_valid_out, rd_data_out,
      output ram_write_enable_out, ram_address_out, ram_data_out,
      output init_done_out, addr_error_out
   );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Two-way round-robin arbiter: on contention the registered priority wins,
// and after any grant priority passes to the requester that was not served.
module rr_arbiter_2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   requester_t prio;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (prio == READ) ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prio <= READ;
      end else if (grant[1]) begin
         prio <= WRITE;
      end else if (grant[0]) begin
         prio <= READ;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Owns the single RAM port: optional post-reset zero sweep, then round-robin
// sharing between the loader (write) and the read path.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_DATA_BITS  = 32,
   parameter int NUM_RAM_WORDS  = 19,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic             clk,
   input logic             reset,
   ram_port_arbiter_if.slave bus
);

   localparam int ADDR_BITS = addr_bits(NUM_RAM_WORDS);
   localparam logic [ADDR_BITS:0]   WORD_LIMIT = (ADDR_BITS + 1)'(NUM_RAM_WORDS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_RAM_WORDS - 1);

   arb_state_t               state;
   logic [ADDR_BITS-1:0]     clear_addr;
   logic [ADDR_BITS-1:0]     last_addr;
   logic [NUM_DATA_BITS-1:0] last_data;
   logic                     run;
   logic [1:0]               req;
   logic [1:0]               grant;
   logic                     wr_grant;
   logic                     rd_grant;
   logic                     wr_oor;
   logic                     rd_oor;

   // Gating requests with reset keeps both readies low while reset is held.
   assign run = reset && (state == RUN);
   assign req = {bus.rd_valid_in & run, bus.wr_valid_in & run};

   rr_arbiter_2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   assign wr_grant = grant[1'(WRITE)];
   assign rd_grant = grant[1'(READ)];
   assign wr_oor   = {1'b0, bus.wr_address_in} >= WORD_LIMIT;
   assign rd_oor   = {1'b0, bus.rd_address_in} >= WORD_LIMIT;

   assign bus.wr_ready_out = wr_grant;
   assign bus.rd_ready_out = rd_grant;
   assign bus.rd_data_out  = bus.ram_data_in;

   always_comb begin
      bus.ram_write_enable_out = 1'b0;
      bus.ram_address_out      = last_addr;
      bus.ram_data_out         = last_data;
      if (reset && (state == CLEAR)) begin
         bus.ram_write_enable_out = 1'b1;
         bus.ram_address_out      = clear_addr;
         bus.ram_data_out         = '0;
      end else if (wr_grant) begin
         bus.ram_write_enable_out = !wr_oor;
         bus.ram_address_out      = bus.wr_address_in;
         bus.ram_data_out         = bus.wr_data_in;
      end else if (rd_grant) begin
         bus.ram_address_out      = bus.rd_address_in;
      end
   end

   // Idle cycles replay the last driven address/data instead of following inputs.
   always_ff @(posedge clk) begin
      last_addr <= bus.ram_address_out;
      last_data <= bus.ram_data_out;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= CLEAR_ON_RESET ? CLEAR : RUN;
         clear_addr         <= '0;
         bus.rd_valid_out   <= 1'b0;
         bus.init_done_out  <= 1'b0;
         bus.addr_error_out <= 1'b0;
      end else begin
         bus.rd_valid_out <= rd_grant;
         if (state == CLEAR) begin
            clear_addr <= clear_addr + 1'b1;
            if (clear_addr == LAST_ADDR) begin
               state             <= RUN;
               bus.init_done_out <= 1'b1;
            end
         end else begin
            bus.init_done_out <= 1'b1;
            if ((wr_grant && wr_oor) || (rd_grant && rd_oor)) begin
               bus.addr_error_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle RAM and a
// read-data scoreboard checked by an independent monitor.
module tb_ram_port_arbiter;

   localparam int NW = 19;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
      bit          chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned passed = 0;
   exp_t        sb[$];
   logic [31:0] exp_mem [0:NW-1];
   logic [31:0] ram [0:NW-1];

   ram_port_arbiter_if #(.NUM_DATA_BITS(DW), .NUM_RAM_WORDS(NW)) bus ();

   ram_port_arbiter #(
      .NUM_DATA_BITS  (DW),
      .NUM_RAM_WORDS  (NW),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Single-ported RAM with registered read, write-before-later-read.
   always @(posedge clk) begin
      if (bus.ram_write_enable_out === 1'b1 && int'(bus.ram_address_out) < NW)
         ram[bus.ram_address_out] <= bus.ram_data_out;
      bus.ram_data_in <= (int'(bus.ram_address_out) < NW) ? ram[bus.ram_address_out] : 32'hBAD0_BAD0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   always @(negedge clk) begin
      if (bus.rd_valid_out === 1'b1) begin
         exp_t e;
         if (sb.size() == 0) begin
            check("rd_valid_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("rd_latency", 32'(cyc), 32'(e.cyc));
            if (e.chk) check("rd_data", bus.rd_data_out, e.data);
         end
      end
   end

   task automatic reset_cycles(input int n);
      bus.wr_valid_in = 1'b1;
      bus.rd_valid_in = 1'b1;
      repeat (n) begin
         @(negedge clk); #1;
         check("rst_wr_ready", 32'(bus.wr_ready_out), 32'd0);
         check("rst_rd_ready", 32'(bus.rd_ready_out), 32'd0);
         check("rst_we", 32'(bus.ram_write_enable_out), 32'd0);
         check("rst_init_done", 32'(bus.init_done_out), 32'd0);
         check("rst_addr_error", 32'(bus.addr_error_out), 32'd0);
         check("rst_rd_valid", 32'(bus.rd_valid_out), 32'd0);
      end
      bus.wr_valid_in = 1'b0;
      bus.rd_valid_in = 1'b0;
      reset = 1'b1;
   endtask

   task automatic sweep(input int stop_at);
      bus.wr_valid_in = 1'b1;
      bus.rd_valid_in = 1'b1;
      for (int k = 0; k < NW; k++) begin
         #1;
         check("clr_we", 32'(bus.ram_write_enable_out), 32'd1);
         check("clr_addr", 32'(bus.ram_address_out), 32'(k));
         check("clr_data", bus.ram_data_out, 32'd0);
         check("clr_wr_ready", 32'(bus.wr_ready_out), 32'd0);
         check("clr_rd_ready", 32'(bus.rd_ready_out), 32'd0);
         check("clr_init_done", 32'(bus.init_done_out), 32'd0);
         if (k == stop_at) begin
            bus.wr_valid_in = 1'b0;
            bus.rd_valid_in = 1'b0;
            reset = 1'b0;
            return;
         end
         if (k == NW - 1) begin
            bus.wr_valid_in = 1'b0;
            bus.rd_valid_in = 1'b0;
         end
         @(negedge clk);
      end
      #1;
      check("init_done", 32'(bus.init_done_out), 32'd1);
      check("post_clear_we", 32'(bus.ram_write_enable_out), 32'd0);
      foreach (exp_mem[i]) exp_mem[i] = '0;
      @(negedge clk);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
      int unsigned n = 0;
      bus.wr_valid_in   = 1'b1;
      bus.wr_address_in = a;
      bus.wr_data_in    = d;
      #1;
      while (bus.wr_ready_out !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("wr_handshake", 32'(bus.wr_ready_out), 32'd1);
      if (bus.wr_ready_out === 1'b1) begin
         if (int'(a) < NW) begin
            check("wr_we", 32'(bus.ram_write_enable_out), 32'd1);
            check("wr_addr", 32'(bus.ram_address_out), 32'(a));
            check("wr_data", bus.ram_data_out, d);
            exp_mem[a] = d;
         end else begin
            check("wr_oor_we", 32'(bus.ram_write_enable_out), 32'd0);
         end
      end
      @(negedge clk);
      bus.wr_valid_in = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input bit chk);
      int unsigned n = 0;
      bus.rd_valid_in   = 1'b1;
      bus.rd_address_in = a;
      #1;
      while (bus.rd_ready_out !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("rd_handshake", 32'(bus.rd_ready_out), 32'd1);
      if (bus.rd_ready_out === 1'b1) begin
         check("rd_we", 32'(bus.ram_write_enable_out), 32'd0);
         check("rd_addr", 32'(bus.ram_address_out), 32'(a));
         sb.push_back('{data: (int'(a) < NW) ? exp_mem[a] : 32'h0, cyc: cyc + 1, chk: chk});
      end
      @(negedge clk);
      bus.rd_valid_in = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got t=%0t, required < 100000", $time);
      $fatal(1);
   end

   initial begin
      int nr;
      int nw;
      reset             = 1'b0;
      bus.wr_valid_in   = 1'b0;
      bus.rd_valid_in   = 1'b0;
      bus.wr_address_in = '0;
      bus.rd_address_in = '0;
      bus.wr_data_in    = '0;

      // Reset with both requesters pushing, then the full zero sweep.
      reset_cycles(3);
      sweep(-1);

      // Contention straight after init: R,W,R,W,R,W.
      nr = 0;
      nw = 0;
      bus.wr_address_in = 5'd1;
      bus.wr_data_in    = 32'h1111_1111;
      bus.rd_address_in = 5'd2;
      bus.wr_valid_in   = 1'b1;
      bus.rd_valid_in   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("cont_rd_ready", 32'(bus.rd_ready_out), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("cont_wr_ready", 32'(bus.wr_ready_out), (i % 2 == 1) ? 32'd1 : 32'd0);
         if (bus.rd_ready_out === 1'b1) begin
            sb.push_back('{data: 32'h0, cyc: cyc + 1, chk: 1'b1});
            nr++;
         end
         if (bus.wr_ready_out === 1'b1) nw++;
         @(negedge clk);
      end
      bus.wr_valid_in = 1'b0;
      bus.rd_valid_in = 1'b0;
      exp_mem[1] = 32'h1111_1111;
      check("cont_reads", 32'(nr), 32'd3);
      check("cont_writes", 32'(nw), 32'd3);

      // Cleared words read back as zero, including both ends.
      do_read(5'd7, 1'b1);
      do_read(5'd0, 1'b1);
      do_read(5'd18, 1'b1);

      // Read-after-write on consecutive grants.
      do_write(5'd5, 32'hDEAD_BEEF);
      do_read(5'd5, 1'b1);

      // Eight back-to-back reads of freshly written words.
      for (int i = 0; i < 8; i++) do_write(AW'(i), 32'hC0DE_0000 + 32'(i * 3));
      bus.rd_valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.rd_address_in = AW'(i);
         #1;
         check("b2b_rd_ready", 32'(bus.rd_ready_out), 32'd1);
         sb.push_back('{data: exp_mem[i], cyc: cyc + 1, chk: 1'b1});
         @(negedge clk);
      end
      bus.rd_valid_in = 1'b0;
      repeat (2) @(negedge clk);

      // Out-of-range accesses and the sticky error flag.
      #1;
      check("err_before", 32'(bus.addr_error_out), 32'd0);
      @(negedge clk);
      do_write(5'd19, 32'h1234_5678);
      #1;
      check("err_set", 32'(bus.addr_error_out), 32'd1);
      @(negedge clk);
      do_read(5'd25, 1'b0);
      do_read(5'd3, 1'b1);
      repeat (3) begin
         @(negedge clk); #1;
         check("err_sticky", 32'(bus.addr_error_out), 32'd1);
      end
      @(negedge clk);

      // Reset mid-sweep at address 10 restarts the full sweep.
      reset = 1'b0;
      reset_cycles(2);
      sweep(10);
      reset_cycles(2);
      sweep(-1);
      do_read(5'd5, 1'b1);
      do_read(5'd1, 1'b1);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
